// File: rtl/barrett_param_gen_64b_if.sv
// Request/result bundle between the Barrett parameter generator and its user.
// The master drives requests; the slave (the generator) returns k/u results.
interface barrett_param_gen_64b_if #(
  parameter int DATAW = 64
);
  localparam int KW = $clog2(DATAW) + 1;

  logic               iClr;
  logic               iStart;
  logic [DATAW-1:0]   iMod;
  logic               oBusy;
  logic               oValid;
  logic               oErr;
  logic [KW-1:0]      oK;
  logic [2*DATAW-1:0] oU;

  modport master (
    output iClr, iStart, iMod,
    input  oBusy, oValid, oErr, oK, oU
  );

  modport slave (
    input  iClr, iStart, iMod,
    output oBusy, oValid, oErr, oK, oU
  );
endinterface

// File: rtl/barrett_param_gen_64b.sv
// Barrett constants k = bitlen(m), u = floor(2^(2k)/m) via a 1-bit/cycle restoring divider.
// Optional BARRETT_PARAM_CACHE_EN keeps the last result and replays it for a repeated modulus.
module barrett_param_gen_64b #(
  parameter int DATAW = 64
) (
  input logic                    iClk,
  input logic                    iRstN,
  barrett_param_gen_64b_if.slave bus
);
  localparam int KW = $clog2(DATAW) + 1;
  localparam int CW = KW + 1;

  typedef enum logic [1:0] {IDLE, LEN, DIV} stateT;

  stateT              state, stateNext;
  logic [DATAW-1:0]   mReg;
  logic [KW-1:0]      kReg, kLen, kOut;
  logic [CW-1:0]      cnt;
  logic [DATAW:0]     rReg, rNext, rDiff;
  logic [DATAW+1:0]   rShift;
  logic [2*DATAW-1:0] qReg, qNext, uOut;
  logic               numBit, qBit;
  logic               validReg, errReg;
  logic               modZero, cacheHit;
  logic               acceptStart, lenErr, lenHit, lenLoad, divLast;

  // Bit length of the captured modulus; the highest set bit wins.
  always_comb begin
    kLen = '0;
    for (int i = 0; i < DATAW; i++) begin
      if (mReg[i]) kLen = KW'(i + 1);
    end
  end

  assign modZero = (mReg == '0);

  // One restoring-division step; the numerator 2^(2k) contributes its single 1 on the first step.
  // A set top bit of rShift already implies rShift >= m, and the low 65 bits of the difference are exact.
  always_comb begin
    numBit = (cnt == {kReg, 1'b0});
    rShift = {rReg, numBit};
    rDiff  = rShift[DATAW:0] - {1'b0, mReg};
    qBit   = rShift[DATAW+1] | (rShift[DATAW:0] >= {1'b0, mReg});
    rNext  = qBit ? rDiff : rShift[DATAW:0];
    qNext  = {qReg[2*DATAW-2:0], qBit};
  end

`ifdef BARRETT_PARAM_CACHE_EN
  logic               cacheValid;
  logic [DATAW-1:0]   cacheMod;
  logic [KW-1:0]      cacheK;
  logic [2*DATAW-1:0] cacheU;

  assign cacheHit = cacheValid && (cacheMod == mReg);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cacheValid <= 1'b0;
      cacheMod   <= '0;
      cacheK     <= '0;
      cacheU     <= '0;
    end else if (bus.iClr || lenErr) begin
      cacheValid <= 1'b0;
    end else if (divLast) begin
      cacheValid <= 1'b1;
      cacheMod   <= mReg;
      cacheK     <= kReg;
      cacheU     <= qNext;
    end
  end
`else
  assign cacheHit = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.iStart) stateNext = LEN;
      LEN:     stateNext = lenLoad ? DIV : IDLE;
      DIV:     if (cnt == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (bus.iClr) stateNext = IDLE;
  end

  always_comb begin
    acceptStart = 1'b0;
    lenErr      = 1'b0;
    lenHit      = 1'b0;
    lenLoad     = 1'b0;
    divLast     = 1'b0;
    case (state)
      IDLE: acceptStart = bus.iStart;
      LEN: begin
        lenErr  = modZero;
        lenHit  = !modZero && cacheHit;
        lenLoad = !modZero && !cacheHit;
      end
      DIV:     divLast = (cnt == '0);
      default: ;
    endcase
  end

  // Datapath and result registers; clear wins over everything that happens in the same cycle.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      mReg     <= '0;
      kReg     <= '0;
      cnt      <= '0;
      rReg     <= '0;
      qReg     <= '0;
      validReg <= 1'b0;
      errReg   <= 1'b0;
      kOut     <= '0;
      uOut     <= '0;
    end else if (bus.iClr) begin
      cnt      <= '0;
      rReg     <= '0;
      qReg     <= '0;
      validReg <= 1'b0;
      errReg   <= 1'b0;
      kOut     <= '0;
      uOut     <= '0;
    end else begin
      validReg <= lenErr | lenHit | divLast;
      if (acceptStart) begin
        mReg   <= bus.iMod;
        errReg <= 1'b0;
      end
      if (state == LEN) kReg <= kLen;
      if (lenErr) begin
        errReg <= 1'b1;
        kOut   <= '0;
        uOut   <= '0;
      end
`ifdef BARRETT_PARAM_CACHE_EN
      if (lenHit) begin
        kOut <= cacheK;
        uOut <= cacheU;
      end
`endif
      if (lenLoad) begin
        cnt  <= {kLen, 1'b0};
        rReg <= '0;
        qReg <= '0;
      end
      if (state == DIV) begin
        rReg <= rNext;
        qReg <= qNext;
        cnt  <= cnt - CW'(1);
      end
      if (divLast) begin
        kOut <= kReg;
        uOut <= qNext;
      end
    end
  end

  assign bus.oBusy  = (state != IDLE);
  assign bus.oValid = validReg;
  assign bus.oErr   = errReg;
  assign bus.oK     = kOut;
  assign bus.oU     = uOut;
endmodule

// File: tb/tb_barrett_param_gen_64b.sv
// Bench for barrett_param_gen_64b: arithmetic reference model checked every cycle plus literal pins.
// Build with BARRETT_PARAM_CACHE_EN defined to exercise the result cache.
module tb_barrett_param_gen_64b;
  localparam int DATAW = 64;
`ifdef BARRETT_PARAM_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic iClk  = 1'b0;
  logic iRstN = 1'b0;

  barrett_param_gen_64b_if #(.DATAW(DATAW)) bus ();
  barrett_param_gen_64b #(.DATAW(DATAW)) dut (.iClk(iClk), .iRstN(iRstN), .bus(bus));

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  logic         expPending = 1'b0;
  int           startCyc   = 0;
  int           expCyc     = 0;
  int           lastLat    = 0;
  logic [63:0]  expMod     = '0;
  logic [6:0]   expK       = '0;
  logic [127:0] expU       = '0;
  logic         expErr     = 1'b0;
  logic [6:0]   holdK      = '0;
  logic [127:0] holdU      = '0;
  logic         holdErr    = 1'b0;
  logic         cacheValid = 1'b0;
  logic [63:0]  cacheMod   = '0;

  function automatic int bitLen(logic [63:0] m);
    int n = 0;
    while (m != 0) begin
      m = m >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic logic [127:0] refU(logic [63:0] m, int k);
    logic [128:0] num, q;
    num = 129'd1 << (2 * k);
    q   = num / {65'd0, m};
    return q[127:0];
  endfunction

  // Barrett reduction of a*b using the generated k/u, as the downstream multiplier does it.
  function automatic logic [127:0] barrettMul(logic [63:0] m, int k, logic [127:0] u,
                                              logic [63:0] a, logic [63:0] b);
    logic [191:0] x, q, r;
    x = {128'd0, a} * {128'd0, b};
    q = ((x >> (k - 1)) * {64'd0, u}) >> (k + 1);
    r = x - q * {128'd0, m};
    for (int i = 0; i < 3; i++) begin
      if (r >= {128'd0, m}) r = r - {128'd0, m};
    end
    return r[127:0];
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge iClk) begin
    if (expPending && cyc == expCyc) begin
      logic [63:0] a, b;
      checkOutput("validPulse", {126'd0, bus.oValid, bus.oBusy}, 128'd2);
      checkOutput("resultK", {121'd0, bus.oK}, {121'd0, expK});
      checkOutput("resultU", bus.oU, expU);
      checkOutput("resultErr", {127'd0, bus.oErr}, {127'd0, expErr});
      lastLat    = cyc - startCyc;
      holdK      = expK;
      holdU      = expU;
      holdErr    = expErr;
      expPending = 1'b0;
      if (!expErr) begin
        a = {$urandom, $urandom} % expMod;
        b = {$urandom, $urandom} % expMod;
        checkOutput("barrett", barrettMul(expMod, int'(expK), bus.oU, a, b),
                    ({64'd0, a} * {64'd0, b}) % {64'd0, expMod});
      end
    end else begin
      checkOutput(expPending ? "busyPhase" : "idlePhase",
                  {126'd0, bus.oValid, bus.oBusy}, {127'd0, expPending});
      checkOutput("holdK", {121'd0, bus.oK}, {121'd0, holdK});
      checkOutput("holdU", bus.oU, holdU);
      checkOutput("holdErr", {127'd0, bus.oErr}, {127'd0, holdErr});
    end
  end

  task automatic waitResult();
    int guard = 0;
    while (expPending && guard < 400) begin
      @(negedge iClk);
      #1;
      guard++;
    end
    checkOutput("resultTimeout", {127'd0, expPending}, 128'd0);
  endtask

  // Issues a start as early as the DUT can accept it and records the model's expectation.
  task automatic applyStimulus(input logic [63:0] mod, input int holdCycles);
    int k, lat;
    waitResult();
    bus.iStart = 1'b1;
    bus.iMod   = mod;
    @(posedge iClk);
    #1;
    k        = bitLen(mod);
    startCyc = cyc;
    expMod   = mod;
    holdErr  = 1'b0;
    if (mod == 0) begin
      expK       = '0;
      expU       = '0;
      expErr     = 1'b1;
      lat        = 1;
      cacheValid = 1'b0;
    end else begin
      expK   = 7'(k);
      expU   = refU(mod, k);
      expErr = 1'b0;
      lat    = (CACHE_EN && cacheValid && cacheMod == mod) ? 1 : 2 * k + 2;
      cacheValid = 1'b1;
      cacheMod   = mod;
    end
    expCyc     = startCyc + lat;
    expPending = 1'b1;
    for (int i = 0; i < holdCycles; i++) begin
      bus.iMod = ~mod;
      @(posedge iClk);
      #1;
    end
    bus.iStart = 1'b0;
  endtask

  task automatic pulseClr(input logic withStart);
    bus.iClr   = 1'b1;
    bus.iStart = withStart;
    bus.iMod   = 64'd7681;
    @(posedge iClk);
    #1;
    bus.iClr   = 1'b0;
    bus.iStart = 1'b0;
    expPending = 1'b0;
    holdK      = '0;
    holdU      = '0;
    holdErr    = 1'b0;
    cacheValid = 1'b0;
  endtask

  task automatic checkResult(input string name, input logic [6:0] k, input logic [127:0] u,
                             input logic err, input int lat);
    waitResult();
    checkOutput({name, "_k"}, {121'd0, bus.oK}, {121'd0, k});
    checkOutput({name, "_u"}, bus.oU, u);
    checkOutput({name, "_err"}, {127'd0, bus.oErr}, {127'd0, err});
    checkOutput({name, "_lat"}, 128'(lastLat), 128'(lat));
  endtask

  initial begin
    logic [63:0] m;
    bus.iClr   = 1'b0;
    bus.iStart = 1'b0;
    bus.iMod   = '0;
    repeat (3) @(negedge iClk);
    #1;
    checkOutput("rstState", {bus.oBusy, bus.oValid, bus.oErr, bus.oK, bus.oU}, '0);
    @(posedge iClk);
    #1;
    iRstN = 1'b1;

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 0);
    checkResult("mAllOnes", 7'd64, 128'h1_0000_0000_0000_0001, 1'b0, 130);
    applyStimulus(64'd7681, 3);
    checkResult("m7681", 7'd13, 128'd8736, 1'b0, 28);
    applyStimulus(64'd7681, 0);
    checkResult("m7681Repeat", 7'd13, 128'd8736, 1'b0, CACHE_EN ? 1 : 28);
    pulseClr(1'b0);
    applyStimulus(64'd7681, 0);
    checkResult("m7681AfterClr", 7'd13, 128'd8736, 1'b0, 28);
    applyStimulus(64'd1, 0);
    checkResult("m1", 7'd1, 128'd4, 1'b0, 4);
    applyStimulus(64'd0, 0);
    checkResult("m0", 7'd0, 128'd0, 1'b1, 1);
    applyStimulus(64'd3, 0);
    checkResult("m3", 7'd2, 128'd5, 1'b0, 6);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 0);
    while (cyc < startCyc + 39) begin
      @(negedge iClk);
      #1;
    end
    pulseClr(1'b1);
    repeat (140) @(negedge iClk);
    #1;

    applyStimulus(64'd7681, 0);
    repeat (10) @(posedge iClk);
    #1;
    iRstN      = 1'b0;
    expPending = 1'b0;
    holdK      = '0;
    holdU      = '0;
    holdErr    = 1'b0;
    cacheValid = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRstN = 1'b1;
    applyStimulus(64'd7681, 0);
    checkResult("m7681AfterRst", 7'd13, 128'd8736, 1'b0, 28);

    for (int n = 0; n < 300; n++) begin
      m = {$urandom, $urandom};
      if (n % 2 == 0) m[63] = 1'b1;
      else            m = m >> $urandom_range(0, 63);
      if (m == 0) m = 64'd1;
      applyStimulus(m, 0);
    end
    waitResult();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
